// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and frame constants common to
// the transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_e;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-facing UART bundle: line input, oversample enable, consumer
// acknowledge and the received byte with its status flags.
interface uart_receiver_if;
   import uart_pkg::*;

   logic                      clken_16x;
   logic                      Rx;
   logic                      rdy_clr;
   logic [UART_DATA_BITS-1:0] data_out;
   logic                      rdy;
   logic                      frame_err;
   logic                      overrun;
   logic                      Rx_busy;

   modport master (
      output clken_16x, Rx, rdy_clr,
      input  data_out, rdy, frame_err, overrun, Rx_busy
   );

   modport slave (
      input  clken_16x, Rx, rdy_clr,
      output data_out, rdy, frame_err, overrun, Rx_busy
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is
// a parameter so idle-high and idle-low lines can share it.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, sticky ready /
// frame-error / overrun flags cleared by the consumer.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   uart_receiver_if.slave bus
);

   localparam int                CNT_W    = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic                      rx_s;
   uart_state_e               state;
   logic [CNT_W-1:0]          sample_cnt;
   logic [2:0]                bit_pos;
   logic [UART_DATA_BITS-1:0] shreg;
   logic [UART_DATA_BITS-1:0] data_q;
   logic                      rdy_q;
   logic                      ferr_q;
   logic                      ovr_q;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .d       (bus.Rx),
      .q       (rx_s)
   );

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_pos    <= '0;
         shreg      <= '0;
         data_q     <= '0;
         rdy_q      <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         // Clear first so a completion on the same edge overrides it.
         if (bus.rdy_clr) begin
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
         end
         if (bus.clken_16x) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state      <= START;
                     sample_cnt <= CNT_W'(1);
                  end
               end
               START: begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else if (sample_cnt == CNT_HALF) begin
                     state      <= DATA;
                     sample_cnt <= '0;
                     bit_pos    <= '0;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
               DATA: begin
                  sample_cnt <= sample_cnt + 1'b1;
                  if (sample_cnt == CNT_LAST) begin
                     shreg[bit_pos] <= rx_s;
                     if (bit_pos == LAST_BIT) state <= STOP;
                     else                     bit_pos <= bit_pos + 1'b1;
                  end
               end
               STOP: begin
                  sample_cnt <= sample_cnt + 1'b1;
                  // Leave at mid-stop so a back-to-back start edge is not missed.
                  if (sample_cnt == CNT_LAST) begin
                     state <= IDLE;
                     if (rx_s) begin
                        data_q <= shreg;
                        rdy_q  <= 1'b1;
                        if (rdy_q) ovr_q <= 1'b1;
                     end else begin
                        ferr_q <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.data_out  = data_q;
   assign bus.rdy       = rdy_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
   assign bus.Rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver; expected flags come from a
// frame-level model of the sticky status rules.
module tb_uart_receiver;

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;

   uart_receiver_if ifc ();

   uart_receiver #(.OVERSAMPLE(16)) u_dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .bus     (ifc)
   );

   always #10 clk_50m = ~clk_50m;

   // Oversample enable: one cycle high every div clocks; tick_no counts pulses.
   int          div     = 27;
   int          phase   = 0;
   int unsigned tick_no = 0;

   initial begin
      ifc.clken_16x = 1'b0;
      forever begin
         @(posedge clk_50m);
         #1;
         if (phase >= div - 1) begin
            phase         = 0;
            ifc.clken_16x = 1'b1;
            tick_no++;
         end else begin
            phase++;
            ifc.clken_16x = 1'b0;
         end
      end
   end

   // Observation of completed bytes and busy activity.
   logic [7:0] got[$];
   logic       rdy_d    = 1'b0;
   int         busy_cnt = 0;

   always @(negedge clk_50m) begin
      if (ifc.rdy && !rdy_d) got.push_back(ifc.data_out);
      rdy_d = ifc.rdy;
      if (ifc.Rx_busy) busy_cnt++;
   end

   int checks   = 0;
   int failures = 0;

   initial begin
      #4000000;
      failures++;
      $display("FAIL timeout: simulation did not complete (observed=running required=done)");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Reference model of the consumer-visible state.
   logic [7:0] m_data;
   logic       m_rdy, m_fe, m_ovr;

   task automatic model_reset();
      m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_clear();
      m_rdy = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic good, input logic clr);
      logic was_rdy;
      was_rdy = m_rdy;
      if (clr) model_clear();
      if (good) begin
         m_data = b;
         m_rdy  = 1'b1;
         if (was_rdy) m_ovr = 1'b1;
      end else begin
         m_fe = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data_out"},  ifc.data_out,         m_data);
      check({tag, ".rdy"},       8'(ifc.rdy),          8'(m_rdy));
      check({tag, ".frame_err"}, 8'(ifc.frame_err),    8'(m_fe));
      check({tag, ".overrun"},   8'(ifc.overrun),      8'(m_ovr));
      check({tag, ".Rx_busy"},   8'(ifc.Rx_busy),      8'h00);
   endtask

   task automatic wait_ticks(input int n);
      int unsigned tgt;
      tgt = tick_no + n;
      wait (tick_no == tgt);
   endtask

   task automatic idle_ticks(input int n);
      ifc.Rx = 1'b1;
      wait_ticks(n);
   endtask

   task automatic pulse_clr();
      ifc.rdy_clr = 1'b1;
      @(posedge clk_50m);
      #1;
      ifc.rdy_clr = 1'b0;
   endtask

   // One frame, each bit 16 ticks; starts and ends on a tick boundary.
   // A low stop bit is held 10 ticks so the line recovers before a false start.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic clr_start, input logic clr_stop);
      ifc.Rx = 1'b0;
      if (clr_start) begin
         pulse_clr();
         model_clear();
      end
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         ifc.Rx = b[i];
         wait_ticks(16);
      end
      ifc.Rx = stop_bit;
      wait_ticks(8);
      if (clr_stop) pulse_clr();
      wait_ticks(2);
      ifc.Rx = 1'b1;
      wait_ticks(6);
      model_frame(b, stop_bit, clr_stop);
   endtask

   initial begin
      int         base;
      int         bbase;
      logic [7:0] rb;
      logic       rstop;
      int         mode;

      ifc.Rx      = 1'b1;
      ifc.rdy_clr = 1'b0;
      model_reset();
      repeat (4) @(posedge clk_50m);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // Single byte at ~115200 baud, then acknowledge.
      div = 27;
      idle_ticks(4);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check_all("a5");
      pulse_clr();
      model_clear();
      check("a5_clr.rdy", 8'(ifc.rdy), 8'h00);

      // Back-to-back frames with acknowledge between them.
      div = 8;
      idle_ticks(3);
      base = got.size();
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      check_all("b2b");
      check("b2b.count", 8'(got.size() - base), 8'h02);
      check("b2b.first", got[base], 8'h00);
      check("b2b.second", got[base + 1], 8'hFF);
      pulse_clr();
      model_clear();
      idle_ticks(2);

      // Short low glitch on the idle line.
      bbase  = busy_cnt;
      base   = got.size();
      ifc.Rx = 1'b0;
      wait_ticks(4);
      idle_ticks(12);
      check("glitch.busy_seen", 8'(busy_cnt > bbase), 8'h01);
      check("glitch.no_byte", 8'(got.size() - base), 8'h00);
      check_all("glitch");

      // Framing error, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check_all("ferr");
      idle_ticks(4);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      check_all("ferr_recover");
      pulse_clr();
      model_clear();
      idle_ticks(2);

      // Overrun, then acknowledge on the very completion edge.
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      check_all("overrun");
      send_frame(8'h33, 1'b1, 1'b0, 1'b1);
      check_all("clr_vs_set");

      // Reset during data bit 4 of a frame.
      ifc.Rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         ifc.Rx = i[0];
         wait_ticks(16);
      end
      ifc.Rx = 1'b1;
      wait_ticks(4);
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all("async_reset");
      @(posedge clk_50m);
      #1;
      rst_n = 1'b1;
      idle_ticks(20);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      check_all("after_reset");

      // Randomized frames, stop bits, acknowledges and baud dividers.
      for (int n = 0; n < 12; n++) begin
         div   = $urandom_range(10, 3);
         rb    = 8'($urandom);
         rstop = ($urandom_range(5, 0) != 0);
         mode  = $urandom_range(2, 0);
         idle_ticks($urandom_range(3, 1));
         send_frame(rb, rstop, mode == 1, mode == 2);
         check_all($sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the downstream counterpart of the byte transmitter on the same link, running in the clk_50m domain. It samples the asynchronous Rx line at 16× the baud rate using a single-cycle enable from the shared baud generator, and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop). Completed bytes are presented with a sticky ready flag for the consumer, together with frame-error and overrun status.

## Interface
- OVERSAMPLE, 16: clken_16x ticks per bit; power of two, ≥ 8.
- clk_50m  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clken_16x  input  1  single-cycle enable, OVERSAMPLE pulses per bit period.
- Rx  input  1  asynchronous serial line; idles high.
- rdy_clr  input  1  consumer acknowledge; clears rdy, frame_err and overrun.
- data_out  output  8  last good received byte.
- rdy  output  1  sticky: new byte available in data_out.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: byte completed while rdy was still 1.
- Rx_busy  output  1  high whenever state ≠ IDLE.

## Operation
- Rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use rx_s (the synchronizer output).
- State is sampled only on cycles with clken_16x = 1. Exceptions: rdy_clr and reset act on any cycle.
- sample_cnt width is log2(OVERSAMPLE) and wraps naturally. bit_pos is 3 bits. shreg is 8 bits.
- IDLE: rx_s = 0 → START, sample_cnt ← 1.
- START:
  - rx_s = 1 → IDLE (glitch rejected; no status change).
  - sample_cnt = OVERSAMPLE/2−1 → DATA, sample_cnt ← 0, bit_pos ← 0. This aligns sampling to mid-bit.
  - Otherwise sample_cnt++.
- DATA:
  - sample_cnt++ each tick.
  - At sample_cnt = OVERSAMPLE−1: shreg[bit_pos] ← rx_s.
  - At that tick, bit_pos = 7 → STOP; otherwise bit_pos++.
- STOP:
  - sample_cnt++ each tick.
  - At sample_cnt = OVERSAMPLE−1 with rx_s = 1:
    - data_out ← shreg, rdy ← 1.
    - overrun ← 1 if rdy was already 1.
    - → IDLE.
  - At sample_cnt = OVERSAMPLE−1 with rx_s = 0:
    - frame_err ← 1; data_out and rdy unchanged.
    - → IDLE.
- Returning to IDLE at mid-stop-bit lets back-to-back frames be detected without loss.
- rdy_clr = 1 clears rdy, frame_err and overrun on the next edge. If a set event occurs on the same cycle, the set wins.
- Unused state encodings → IDLE.

## Timing
- Reset values:
  - data_out = 8'h00; rdy = frame_err = overrun = 0; Rx_busy = 0.
  - state = IDLE; sync flops = 1; counters = 0.
- Reset mid-frame aborts immediately. The partial byte is discarded.
- Rx to rx_s: 2 clk_50m cycles.
- Start detection: first clken_16x tick after rx_s falls.
- Latency: rdy rises on the clk_50m edge after the mid-stop-bit tick. That is 9.5 bit periods (±1 tick + 2 clk) after the Rx falling edge.
- Outputs are registered.
- Rx_busy is decoded from registered state.
- data_out is stable while rdy = 1 unless an overrun occurs.
- A start pulse shorter than OVERSAMPLE/2 ticks is rejected.

## Structure
- Shared package uart_pkg:
  - State encodings IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11, identical to the transmitter's.
  - UART_OVERSAMPLE = 16.
  - Frame constants: UART_DATA_BITS = 8.
- One sub-module: sync_2ff (1-bit, reset value parameter = 1). It is reused by other async inputs.
- The FSM, counters and status flags stay in uart_receiver.

## Test plan
- Byte 8'hA5, clken_16x every 27 clk (≈115200 baud) → data_out = 8'hA5, rdy = 1, frame_err = 0, overrun = 0. rdy_clr → rdy = 0 the next cycle.
- Frames 8'h00 then 8'hFF back-to-back (stop immediately followed by start), rdy_clr after each → both bytes received in order; no frame_err.
- 4-tick low glitch on idle Rx → Rx_busy pulses, then returns to IDLE; rdy stays 0; data_out unchanged.
- Frame 8'h3C with stop bit driven low → frame_err = 1, rdy = 0, data_out retains its previous value. A following good 8'h3C → rdy = 1.
- Two frames 8'h11, 8'h22 without rdy_clr → data_out = 8'h22, rdy = 1, overrun = 1. rdy_clr coincident with a third completion → rdy = 1 (set wins).
- rst_n asserted at bit 4 of a frame → all outputs return to reset values asynchronously. The next full frame 8'h5A is received correctly.
